// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, halt detection,
// single-step / continuous run control and a saturating fetch counter.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_step_mode,
    input  logic        i_step,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [1:0]  i_pc_src,
    input  logic [31:0] i_branch_addr,
    input  logic [31:0] i_jump_addr,
    input  logic [31:0] i_jr_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic [31:0] o_fetch_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_ifIdInstr;
    logic [31:0] r_ifIdPc4;
    logic        r_ifIdValid;
    logic [31:0] r_fetchCount;

    logic        w_adv;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_redirect;
    logic [31:0] w_nextPc;
    logic [31:0] w_nextInstr;
    logic [31:0] w_nextPc4;
    logic        w_nextValid;
    logic [31:0] w_nextCount;

    assign w_adv     = (r_state == ST_RUN) && (i_step_mode ? i_step : i_enable);
    assign w_pcPlus4 = r_pc + 32'd4;

    // Redirect target chosen by the hazard unit's PC source select.
    always_comb begin
        w_redirect = w_pcPlus4;
        case (i_pc_src)
            2'b00:   w_redirect = w_pcPlus4;
            2'b01:   w_redirect = i_branch_addr;
            2'b10:   w_redirect = i_jump_addr;
            default: w_redirect = i_jr_addr;
        endcase
    end

    // Next-state logic: stall beats flush beats normal fetch; everything holds otherwise.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_nextInstr = r_ifIdInstr;
        w_nextPc4   = r_ifIdPc4;
        w_nextValid = r_ifIdValid;
        w_nextCount = r_fetchCount;
        if (w_adv && !i_stall) begin
            if (i_flush) begin
                w_nextInstr = NOP_INSTR;
                w_nextPc4   = 32'd0;
                w_nextValid = 1'b0;
                w_nextPc    = w_redirect;
            end else begin
                w_nextInstr = i_imem_data;
                w_nextPc4   = w_pcPlus4;
                w_nextValid = 1'b1;
                if (r_fetchCount != 32'hFFFFFFFF) begin
                    w_nextCount = r_fetchCount + 32'd1;
                end
                if (i_imem_data == HALT_INSTR) begin
                    w_nextState = ST_HALTED;
                end else begin
                    w_nextPc = w_pcPlus4;
                end
            end
        end
    end

    // FSM state register; only reset leaves HALTED.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_ifIdInstr  <= NOP_INSTR;
            r_ifIdPc4    <= 32'd0;
            r_ifIdValid  <= 1'b0;
            r_fetchCount <= 32'd0;
        end else begin
            r_pc         <= w_nextPc;
            r_ifIdInstr  <= w_nextInstr;
            r_ifIdPc4    <= w_nextPc4;
            r_ifIdValid  <= w_nextValid;
            r_fetchCount <= w_nextCount;
        end
    end

    assign o_pc          = r_pc;
    assign o_imem_addr   = r_pc;
    assign o_if_id_instr = r_ifIdInstr;
    assign o_if_id_pc4   = r_ifIdPc4;
    assign o_if_id_valid = r_ifIdValid;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_fetch_count = r_fetchCount;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: fetch, stall, flush, halt, step and PC wrap.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stepMode;
    logic        step;
    logic        stall;
    logic        flush;
    logic [1:0]  pcSrc;
    logic [31:0] branchAddr;
    logic [31:0] jumpAddr;
    logic [31:0] jrAddr;
    logic [31:0] imemData;
    logic [31:0] imemAddr;
    logic [31:0] pc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic        ifIdValid;
    logic        halted;
    logic [31:0] fetchCount;

    logic        wReset;
    logic        wEnable;
    logic [31:0] wImemData;
    logic [31:0] wImemAddr;
    logic [31:0] wPc;
    logic [31:0] wInstr;
    logic [31:0] wPc4;
    logic        wValid;
    logic        wHalted;
    logic [31:0] wCount;

    logic [31:0] imem [0:63];
    int          checks;
    int          errors;

    assign imemData  = imem[imemAddr[7:2]];
    assign wImemData = imem[wImemAddr[7:2]];

    if_fetch_stage dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_step_mode(stepMode),
        .i_step(step), .i_stall(stall), .i_flush(flush), .i_pc_src(pcSrc),
        .i_branch_addr(branchAddr), .i_jump_addr(jumpAddr), .i_jr_addr(jrAddr),
        .i_imem_data(imemData), .o_imem_addr(imemAddr), .o_pc(pc),
        .o_if_id_instr(ifIdInstr), .o_if_id_pc4(ifIdPc4), .o_if_id_valid(ifIdValid),
        .o_halted(halted), .o_fetch_count(fetchCount)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dutWrap (
        .i_clk(clk), .i_reset(wReset), .i_enable(wEnable), .i_step_mode(1'b0),
        .i_step(1'b0), .i_stall(1'b0), .i_flush(1'b0), .i_pc_src(2'b00),
        .i_branch_addr(32'd0), .i_jump_addr(32'd0), .i_jr_addr(32'd0),
        .i_imem_data(wImemData), .o_imem_addr(wImemAddr), .o_pc(wPc),
        .o_if_id_instr(wInstr), .o_if_id_pc4(wPc4), .o_if_id_valid(wValid),
        .o_halted(wHalted), .o_fetch_count(wCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full clock; inputs change and outputs are sampled on falling edges.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc got %h expected %h", pc, 32'd0); end
        checks++; if (ifIdInstr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got %h expected %h", ifIdInstr, 32'd0); end
        checks++; if (ifIdPc4 !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc4 got %h expected %h", ifIdPc4, 32'd0); end
        checks++; if (ifIdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", ifIdValid); end
        checks++; if (fetchCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", fetchCount); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b expected 0", halted); end
        checks++; if (imemAddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_imem_addr got %h expected 0", imemAddr); end
        enable = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        $display("[TB] test_sequential");
        doReset();
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (ifIdInstr !== 32'(k)) begin errors++; $display("[TB] FAIL seq_instr%0d got %h expected %h", k, ifIdInstr, 32'(k)); end
            checks++; if (ifIdPc4 !== 32'(4 * k)) begin errors++; $display("[TB] FAIL seq_pc4_%0d got %h expected %h", k, ifIdPc4, 32'(4 * k)); end
            checks++; if (ifIdValid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid%0d got %b expected 1", k, ifIdValid); end
        end
        checks++; if (pc !== 32'd16) begin errors++; $display("[TB] FAIL seq_pc got %h expected %h", pc, 32'd16); end
        checks++; if (fetchCount !== 32'd4) begin errors++; $display("[TB] FAIL seq_count got %0d expected 4", fetchCount); end
        enable = 1'b0;
    endtask

    task automatic test_stall();
        $display("[TB] test_stall");
        doReset();
        enable = 1'b1;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (pc !== 32'd8) begin errors++; $display("[TB] FAIL stall_pc%0d got %h expected %h", k, pc, 32'd8); end
            checks++; if (ifIdInstr !== 32'd2) begin errors++; $display("[TB] FAIL stall_instr%0d got %h expected %h", k, ifIdInstr, 32'd2); end
            checks++; if (ifIdPc4 !== 32'd8) begin errors++; $display("[TB] FAIL stall_pc4_%0d got %h expected %h", k, ifIdPc4, 32'd8); end
            checks++; if (fetchCount !== 32'd2) begin errors++; $display("[TB] FAIL stall_count%0d got %0d expected 2", k, fetchCount); end
        end
        stall = 1'b0;
        tick();
        checks++; if (ifIdInstr !== 32'd3) begin errors++; $display("[TB] FAIL stall_resume_instr got %h expected %h", ifIdInstr, 32'd3); end
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL stall_resume_pc got %h expected %h", pc, 32'd12); end
        checks++; if (fetchCount !== 32'd3) begin errors++; $display("[TB] FAIL stall_resume_count got %0d expected 3", fetchCount); end
        // enable low: a flush request must not move anything
        enable = 1'b0;
        flush = 1'b1;
        pcSrc = 2'b01;
        branchAddr = 32'h40;
        tick();
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL idle_pc got %h expected %h", pc, 32'd12); end
        checks++; if (ifIdValid !== 1'b1) begin errors++; $display("[TB] FAIL idle_valid got %b expected 1", ifIdValid); end
        flush = 1'b0;
        // reset while stalled acts immediately
        enable = 1'b1;
        stall = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL stall_reset_pc got %h expected 0", pc); end
        checks++; if (fetchCount !== 32'd0) begin errors++; $display("[TB] FAIL stall_reset_count got %0d expected 0", fetchCount); end
        tick();
        reset = 1'b0;
        stall = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_flush();
        $display("[TB] test_flush");
        doReset();
        enable = 1'b1;
        tick();
        tick();
        tick();
        // stall and flush together: stall wins, flush ignored
        stall = 1'b1;
        flush = 1'b1;
        pcSrc = 2'b01;
        branchAddr = 32'h40;
        jumpAddr = 32'h80;
        jrAddr = 32'h20;
        tick();
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL flush_stall_pc got %h expected %h", pc, 32'd12); end
        checks++; if (ifIdValid !== 1'b1) begin errors++; $display("[TB] FAIL flush_stall_valid got %b expected 1", ifIdValid); end
        checks++; if (ifIdInstr !== 32'd3) begin errors++; $display("[TB] FAIL flush_stall_instr got %h expected %h", ifIdInstr, 32'd3); end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("[TB] FAIL flush_branch_pc got %h expected %h", pc, 32'h40); end
        checks++; if (ifIdValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b expected 0", ifIdValid); end
        checks++; if (ifIdInstr !== 32'd0) begin errors++; $display("[TB] FAIL flush_instr got %h expected %h", ifIdInstr, 32'd0); end
        checks++; if (ifIdPc4 !== 32'd0) begin errors++; $display("[TB] FAIL flush_pc4 got %h expected %h", ifIdPc4, 32'd0); end
        checks++; if (fetchCount !== 32'd3) begin errors++; $display("[TB] FAIL flush_count got %0d expected 3", fetchCount); end
        pcSrc = 2'b10;
        tick();
        checks++; if (pc !== 32'h80) begin errors++; $display("[TB] FAIL flush_jump_pc got %h expected %h", pc, 32'h80); end
        pcSrc = 2'b11;
        tick();
        checks++; if (pc !== 32'h20) begin errors++; $display("[TB] FAIL flush_jr_pc got %h expected %h", pc, 32'h20); end
        pcSrc = 2'b00;
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("[TB] FAIL flush_pc4src_pc got %h expected %h", pc, 32'h24); end
        flush = 1'b0;
        tick();
        checks++; if (ifIdInstr !== 32'd10) begin errors++; $display("[TB] FAIL post_flush_instr got %h expected %h", ifIdInstr, 32'd10); end
        checks++; if (ifIdPc4 !== 32'h28) begin errors++; $display("[TB] FAIL post_flush_pc4 got %h expected %h", ifIdPc4, 32'h28); end
        checks++; if (fetchCount !== 32'd4) begin errors++; $display("[TB] FAIL post_flush_count got %0d expected 4", fetchCount); end
        enable = 1'b0;
    endtask

    task automatic test_halt();
        $display("[TB] test_halt");
        imem[3] = 32'hFFFFFFFF;
        doReset();
        enable = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_early got %b expected 0", halted); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag got %b expected 1", halted); end
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL halt_pc got %h expected %h", pc, 32'd12); end
        checks++; if (fetchCount !== 32'd4) begin errors++; $display("[TB] FAIL halt_count got %0d expected 4", fetchCount); end
        checks++; if (ifIdInstr !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL halt_instr got %h expected %h", ifIdInstr, 32'hFFFFFFFF); end
        checks++; if (ifIdValid !== 1'b1) begin errors++; $display("[TB] FAIL halt_valid got %b expected 1", ifIdValid); end
        flush = 1'b1;
        pcSrc = 2'b10;
        jumpAddr = 32'h80;
        tick();
        tick();
        tick();
        flush = 1'b0;
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL halted_hold_pc got %h expected %h", pc, 32'd12); end
        checks++; if (fetchCount !== 32'd4) begin errors++; $display("[TB] FAIL halted_hold_count got %0d expected 4", fetchCount); end
        checks++; if (ifIdValid !== 1'b1) begin errors++; $display("[TB] FAIL halted_hold_valid got %b expected 1", ifIdValid); end
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'd0) begin errors++; $display("[TB] FAIL halt_reset_pc got %h expected 0", pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset_flag got %b expected 0", halted); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (ifIdInstr !== 32'd1) begin errors++; $display("[TB] FAIL restart_instr got %h expected %h", ifIdInstr, 32'd1); end
        checks++; if (pc !== 32'd4) begin errors++; $display("[TB] FAIL restart_pc got %h expected %h", pc, 32'd4); end
        enable = 1'b0;
        imem[3] = 32'd4;
    endtask

    task automatic test_step();
        $display("[TB] test_step");
        doReset();
        stepMode = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            tick();
        end
        checks++; if (fetchCount !== 32'd3) begin errors++; $display("[TB] FAIL step_count got %0d expected 3", fetchCount); end
        checks++; if (pc !== 32'd12) begin errors++; $display("[TB] FAIL step_pc got %h expected %h", pc, 32'd12); end
        checks++; if (ifIdInstr !== 32'd3) begin errors++; $display("[TB] FAIL step_instr got %h expected %h", ifIdInstr, 32'd3); end
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        tick();
        checks++; if (fetchCount !== 32'd5) begin errors++; $display("[TB] FAIL step_held_count got %0d expected 5", fetchCount); end
        checks++; if (pc !== 32'd20) begin errors++; $display("[TB] FAIL step_held_pc got %h expected %h", pc, 32'd20); end
        stepMode = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        checks++; if (wPc !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_reset_pc got %h expected %h", wPc, 32'hFFFFFFFC); end
        wReset = 1'b0;
        wEnable = 1'b1;
        tick();
        wEnable = 1'b0;
        checks++; if (wPc !== 32'd0) begin errors++; $display("[TB] FAIL wrap_pc got %h expected 0", wPc); end
        checks++; if (wPc4 !== 32'd0) begin errors++; $display("[TB] FAIL wrap_pc4 got %h expected 0", wPc4); end
        checks++; if (wInstr !== 32'd64) begin errors++; $display("[TB] FAIL wrap_instr got %h expected %h", wInstr, 32'd64); end
        checks++; if (wCount !== 32'd1) begin errors++; $display("[TB] FAIL wrap_count got %0d expected 1", wCount); end
        tick();
        checks++; if (wPc !== 32'd0) begin errors++; $display("[TB] FAIL wrap_hold_pc got %h expected 0", wPc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) imem[i] = 32'(i + 1);
        reset = 1'b1;
        wReset = 1'b1;
        wEnable = 1'b0;
        enable = 1'b0;
        stepMode = 1'b0;
        step = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        pcSrc = 2'b00;
        branchAddr = 32'd0;
        jumpAddr = 32'd0;
        jrAddr = 32'd0;
        tick();
        reset = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_halt();
        test_step();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter HALT_INSTR, default 32'hFFFFFFFF, instruction word that halts fetch.
REQ-003 Parameter NOP_INSTR, default 32'h00000000, bubble inserted into IF/ID on flush/reset.
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_enable  in  1  run enable, used in continuous mode.
REQ-007 i_step_mode  in  1  0 = continuous, 1 = single-step.
REQ-008 i_step  in  1  one-cycle advance pulse, used in step mode.
REQ-009 i_stall  in  1  load-use stall from hazard unit: hold PC and IF/ID.
REQ-010 i_flush  in  1  control redirect from hazard unit: squash IF/ID and redirect PC.
REQ-011 i_pc_src  in  2  redirect select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
REQ-012 i_branch_addr / i_jump_addr / i_jr_addr  in  32 each  redirect targets.
REQ-013 i_imem_data  in  32  instruction word, combinational read at o_imem_addr.
REQ-014 o_imem_addr  out  32  equals o_pc.
REQ-015 o_pc  out  32  current fetch PC.
REQ-016 o_if_id_instr  out  32  IF/ID instruction register.
REQ-017 o_if_id_pc4  out  32  IF/ID PC+4 register.
REQ-018 o_if_id_valid  out  1  IF/ID holds a real instruction.
REQ-019 o_halted  out  1  state is HALTED.
REQ-020 o_fetch_count  out  32  count of instructions latched valid into IF/ID.

Function
REQ-021 adv = i_step_mode ? i_step : i_enable; state RUN only.
REQ-022 States RUN and HALTED; RUN -> HALTED when HALT_INSTR is latched into IF/ID; HALTED exits only on reset.
REQ-023 In HALTED or with adv=0: PC, IF/ID, and counter all hold.
REQ-024 Priority in RUN with adv=1: i_stall, then i_flush, then normal fetch.
REQ-025 Stall: PC, IF/ID, and counter hold; i_flush is ignored that cycle, and the hazard unit re-asserts it.
REQ-026 Flush (no stall): IF/ID <= {NOP_INSTR, 0, valid=0}; PC <= target selected by i_pc_src; counter holds; no halt detection.
REQ-027 i_pc_src=00 during flush loads PC+4.
REQ-028 Normal: IF/ID <= {i_imem_data, PC+4, valid=1}; PC <= PC+4; counter +1.
REQ-029 PC+4 is a 32-bit modulo sum: 32'hFFFFFFFC wraps to 32'h00000000.
REQ-030 The counter saturates at 32'hFFFFFFFF.
REQ-031 HALT_INSTR latch: it enters IF/ID valid=1 and the counter increments; PC stays at the halt address (not PC+4); o_halted=1 from the next cycle.
REQ-032 Single-step: each i_step pulse gives exactly one advance cycle; i_step held high for N cycles gives N advances.
REQ-033 Latency: an instruction at PC is presented on o_if_id_instr one cycle after its advance edge.

Reset
REQ-034 i_reset asserts asynchronously: o_pc=RESET_PC, o_if_id_instr=NOP_INSTR, o_if_id_pc4=0, o_if_id_valid=0, o_fetch_count=0, state RUN, o_halted=0.
REQ-035 Reset asserted mid-stall, mid-flush, or in HALTED takes effect immediately; the first advance edge after deassertion fetches from RESET_PC.

Verification
REQ-036 Sequential: imem[i]=i+1, i_enable=1, 4 cycles -> IF/ID instr 1,2,3,4; pc4 4,8,12,16; o_pc=16; count=4.
REQ-037 Stall: i_stall=1 for 2 cycles at PC=8 -> PC=8 and IF/ID held both cycles; count unchanged; fetch resumes at 8.
REQ-038 Flush: i_flush=1, i_pc_src=01, i_branch_addr=0x40 -> next cycle valid=0, instr=NOP_INSTR, o_pc=0x40; with i_stall=1 in the same cycle, the flush is ignored.
REQ-039 Halt: imem[3]=HALT_INSTR -> after fetching from PC=12, o_halted=1, o_pc=12, count=4; later cycles with i_enable=1 change nothing; i_reset restores o_pc=0.
REQ-040 Step/wrap: i_step_mode=1, 3 single-cycle i_step pulses spaced by idle cycles -> exactly 3 fetches; with RESET_PC=32'hFFFFFFFC, one advance -> o_pc=0.
